// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two registered read ports (port B immediate mux),
// one write-back port and a per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
module reg_file_sb #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         addr_a,
  input  logic [ADDR_W-1:0]         addr_b,
  input  logic                      use_imm,
  input  logic [BUS_DATA_WIDTH-1:0] imm,
  output logic [BUS_DATA_WIDTH-1:0] data_a,
  output logic [BUS_DATA_WIDTH-1:0] data_b,
  output logic                      hazard,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [BUS_DATA_WIDTH-1:0] wb_data,
  output logic [NUM_REGS-1:0]       busy_vec
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [BUS_DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [BUS_DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic [BUS_DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [BUS_DATA_WIDTH-1:0] data_b_q, data_b_d;

  logic                      fwd_a, fwd_b;
  logic                      pend_a, pend_b;
  logic                      hazard_c;
  logic [BUS_DATA_WIDTH-1:0] val_a, val_b;

  // Storage and scoreboard next state; issue is applied after the clear so set wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wb_en && (wb_addr != '0)) mem_d[wb_addr] = wb_data;
    if (wb_en)    busy_d[wb_addr]    = 1'b0;
    if (issue_en) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // A write-back landing this cycle both forwards its data and hides the busy bit it clears.
  always_comb begin
    fwd_a  = BYPASS && wb_en && (wb_addr == addr_a) && (addr_a != '0);
    fwd_b  = BYPASS && wb_en && (wb_addr == addr_b) && (addr_b != '0);
    pend_a = busy_q[addr_a] && !fwd_a && (addr_a != '0);
    pend_b = busy_q[addr_b] && !fwd_b && (addr_b != '0);
    val_a  = (addr_a == '0) ? '0 : (fwd_a ? wb_data : mem_q[addr_a]);
    val_b  = (addr_b == '0) ? '0 : (fwd_b ? wb_data : mem_q[addr_b]);
    hazard_c = rd_en && (pend_a || (!use_imm && pend_b));
  end

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (rd_en && !hazard_c) begin
      data_a_d = val_a;
      data_b_d = use_imm ? imm : val_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      busy_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      mem_q    <= mem_d;
      busy_q   <= busy_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a   = data_a_q;
  assign data_b   = data_b_q;
  assign hazard   = hazard_c;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed cases then randomized traffic against an array-based model.
module tb_reg_file_sb;
  localparam int W  = 64;
  localparam int N  = 32;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en, use_imm, issue_en, wb_en;
  logic [AW-1:0] addr_a, addr_b, issue_addr, wb_addr;
  logic [W-1:0]  imm, wb_data, data_a, data_b;
  logic          hazard;
  logic [N-1:0]  busy_vec;

  reg_file_sb #(.BUS_DATA_WIDTH(W), .NUM_REGS(N)) dut (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .use_imm(use_imm), .imm(imm), .data_a(data_a), .data_b(data_b), .hazard(hazard),
    .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_mem [N];
  bit           m_busy [N];
  int           checks   = 0;
  int           failures = 0;
  bit           last_haz = 1'b0;
  logic         dut_haz;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] busy_model();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit pend(input logic [AW-1:0] x, input bit we, input logic [AW-1:0] wa);
    return (x != 0) && m_busy[x] && !(BYP && we && (wa == x));
  endfunction

  function automatic logic [W-1:0] val(input logic [AW-1:0] x, input bit we,
                                       input logic [AW-1:0] wa, input logic [W-1:0] wd);
    if (x == 0) return '0;
    if (BYP && we && (wa == x)) return wd;
    return m_mem[x];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // One clock of stimulus, entered and left at a negedge.
  task automatic cycle(input bit re, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                       input bit ui, input logic [W-1:0] im,
                       input bit ie, input logic [AW-1:0] ia,
                       input bit we, input logic [AW-1:0] wa, input logic [W-1:0] wd);
    bit exp_h;
    rd_en = re; addr_a = aa; addr_b = ab; use_imm = ui; imm = im;
    issue_en = ie; issue_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    exp_h   = re && (pend(aa, we, wa) || (!ui && pend(ab, we, wa)));
    dut_haz = hazard;
    chk("hazard", W'(hazard), W'(exp_h));
    if (re && !exp_h)
      exp_q.push_back('{a: val(aa, we, wa, wd), b: ui ? im : val(ab, we, wa, wd)});
    last_haz = exp_h;
    @(posedge clk);
    if (we && (wa != 0)) m_mem[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (ie && (ia != 0)) m_busy[ia] = 1'b1;
    #2;
    chk("busy_vec", W'(busy_vec), W'(busy_model()));
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic read(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                      input bit ui, input logic [W-1:0] im);
    cycle(1'b1, aa, ab, ui, im, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic reset_pulse();
    rd_en = 1'b0; issue_en = 1'b0; wb_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_data_a", data_a, '0);
    chk("rst_data_b", data_b, '0);
    chk("rst_busy", W'(busy_vec), '0);
    chk("rst_hazard", W'(hazard), '0);
    model_clear();
    last_haz = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: a capture happens at an edge where the DUT saw rd_en without hazard.
  initial begin
    bit   fire;
    exp_t e;
    forever begin
      @(negedge clk);
      #3 fire = reset_n && rd_en && !hazard;
      @(posedge clk);
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_capture actual=%h required=no_capture", data_a);
        end else begin
          e = exp_q.pop_front();
          chk("data_a", data_a, e.a);
          chk("data_b", data_b, e.b);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] aa, ab, ia, wa;
    logic [W-1:0]  im;
    bit            re, ui, ie, we;
    int            n;

    reset_n = 1'b0;
    rd_en = 1'b0; addr_a = '0; addr_b = '0; use_imm = 1'b0; imm = '0;
    issue_en = 1'b0; issue_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_clear();
    #1;
    chk("init_data_a", data_a, '0);
    chk("init_busy", W'(busy_vec), '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Post-reset read
    read(AW'(5), AW'(7), 1'b0, '0);
    // Write then read with immediate on B
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, AW'(3), 64'hDEAD_BEEF);
    read(AW'(3), '0, 1'b1, W'(42));
    // Register 0 ignores write and issue
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b1, '0, 64'h1234);
    read('0, '0, 1'b0, '0);

    // Scoreboard stall on register 9
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(9), 1'b0, '0, '0);
    read(AW'(9), '0, 1'b1, W'(1));
    chk("stall_hazard", W'(dut_haz), W'(1));
    read(AW'(9), '0, 1'b1, W'(1));
    cycle(1'b1, AW'(9), '0, 1'b1, W'(1), 1'b0, '0, 1'b1, AW'(9), 64'h55);
    chk("wb_cycle_hazard", W'(dut_haz), W'(!BYP));
    n = 0;
    while (last_haz && n < 4) begin
      read(AW'(9), '0, 1'b1, W'(1));
      n++;
    end

    // Simultaneous issue and write-back to register 4: busy stays set
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(4), 1'b1, AW'(4), 64'h77);
    chk("sim_busy4", W'(busy_vec[4]), W'(1));

    // Mid-stall reset
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(9), 1'b0, '0, '0);
    read(AW'(9), '0, 1'b0, '0);
    chk("midstall_hazard", W'(dut_haz), W'(1));
    reset_pulse();
    read(AW'(9), AW'(4), 1'b0, '0);

    // Randomized traffic with decode holding a stalled request
    re = 1'b0; aa = '0; ab = '0; ui = 1'b0; im = '0;
    for (int c = 0; c < 600; c++) begin
      if (!last_haz) begin
        re = ($urandom % 4) != 0;
        aa = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        ab = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        ui = ($urandom % 3) == 0;
        im = {$urandom, $urandom};
      end
      ie = ($urandom % 3) == 0;
      ia = AW'($urandom_range(0, 9));
      we = ($urandom % 2) != 0;
      wa = AW'($urandom_range(0, 9));
      if ($urandom % 4 != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_busy[wa]) break;
          wa = AW'($urandom_range(0, 9));
        end
      end
      cycle(re, aa, ab, ui, im, ie, ia, we, wa, {$urandom, $urandom});
      if (c == 300) reset_pulse();
    end

    idle();
    idle();
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the core's 32x64 register file. It provides two registered read ports with an immediate mux on port B and one write-back port. It also adds a per-register busy scoreboard with hazard detection and a compile-time write-to-read bypass. It sits between decode (issue/read) and the write-back stage, and feeds operands to the ALU.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, register and operand width
- NUM_REGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  1  request operand capture this cycle
- addr_a  in  ADDR_W  source register A
- addr_b  in  ADDR_W  source register B
- use_imm  in  1  1: port B takes imm; 0: port B takes register addr_b
- imm  in  BUS_DATA_WIDTH  immediate operand
- data_a  out  BUS_DATA_WIDTH  registered operand A
- data_b  out  BUS_DATA_WIDTH  registered operand B
- hazard  out  1  combinational; current read request blocked by a pending write
- issue_en  in  1  an instruction writing issue_addr is issued; marks it busy
- issue_addr  in  ADDR_W  destination of the issued instruction
- wb_en  in  1  write-back valid
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  BUS_DATA_WIDTH  write-back value
- busy_vec  out  NUM_REGS  registered scoreboard bits, bit i = register i pending

## Operation
- Storage: NUM_REGS x BUS_DATA_WIDTH flops. Register 0 always reads 0. Writes to 0 are dropped. issue to 0 never sets busy[0].
- Write: wb_en=1 and wb_addr!=0 -> mem[wb_addr] <= wb_data at the edge. The write is independent of rd_en and hazard, so writes never block reads.
- Scoreboard, per edge:
  - issue_en sets busy[issue_addr].
  - wb_en clears busy[wb_addr].
  - Same address in the same cycle: set wins, because the newer issue is still pending.
- A source is pending when busy[addr] is set and it is not cleared by a write-back in this same cycle (with bypass enabled, see Configuration).
- hazard = rd_en & (pending(addr_a) | (!use_imm & pending(addr_b))). addr 0 is never pending.
- Capture: rd_en & !hazard -> data_a <= value(addr_a); data_b <= use_imm ? imm : value(addr_b).
- Otherwise data_a and data_b hold their previous values.
- value(x) is mem[x], or wb_data when bypass applies.
- Hold-on-hazard: decode keeps rd_en and the addresses stable until hazard drops.

## Timing
- Reset (reset_n low, asynchronous): all mem entries = 0, busy_vec = 0, data_a = 0, data_b = 0. hazard then depends only on inputs and is 0.
- Read latency: 1 cycle. Operands are presented with rd_en at cycle N and are valid on data_a/data_b after edge N.
- Write latency: a write at edge N is visible to a read requested at cycle N+1 without bypass.
- busy_vec updates at the edge following issue_en or wb_en.
- If reset_n is asserted mid-stall, all pending state is discarded. The first post-reset read sees zeros and no hazard.
- Back-to-back issue of the same register without an intervening write-back keeps busy set. The first write-back clears it; the scoreboard is not a counter.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A write-back to address x in cycle N is forwarded to a read of x captured at edge N.
  - busy[x] is treated as clear for the hazard computation in that cycle.
  - Result: read-after-write has zero stall cycles.
- REGFILE_BYPASS_EN undefined:
  - A read at cycle N returns the pre-write mem contents.
  - A busy[x] being cleared in cycle N still raises hazard in cycle N. The read captures at N+1 with the new value.

## Test plan
- Reset: hold reset_n=0, then release; rd_en=1, addr_a=5, addr_b=7, use_imm=0 -> data_a=0, data_b=0, busy_vec=0, hazard=0.
- Write/read: wb_en=1, wb_addr=3, wb_data=64'hDEAD_BEEF; next cycle rd_en=1, addr_a=3, use_imm=1, imm=42 -> data_a=64'hDEAD_BEEF, data_b=42 after one edge.
- x0: wb_en=1, wb_addr=0, wb_data=64'h1234; issue_en=1, issue_addr=0; then read addr_a=0 -> data_a=0, busy_vec[0]=0, hazard=0.
- Scoreboard stall: issue_en with issue_addr=9; next cycle rd_en=1, addr_a=9 -> hazard=1 and data_a held. wb 9=64'h55 arrives 3 cycles later:
  - With REGFILE_BYPASS_EN: hazard drops that cycle and data_a=64'h55 one edge later.
  - Without REGFILE_BYPASS_EN: hazard drops one cycle later and data_a=64'h55 one edge after that.
- Simultaneous issue and write-back: issue_en and wb_en both target register 4 in the same cycle -> busy_vec[4]=1 after the edge and mem[4]=wb_data.
- Mid-stall reset: with busy[9]=1 and hazard asserted, pulse reset_n low asynchronously -> busy_vec=0 and data_a=0 immediately; a subsequent read of 9 returns 0 with hazard=0.
